// File: rtl/deserial_frame_rx.sv
// deserial_frame_rx: framed serial receiver.
// Oversamples serial_clk/serial_i on clk_i, hunts for HEADER, shifts payload bits until
// FOOTER is seen, then presents an LSB-aligned payload and its length on a single-entry
// valid/ready output register.
// Ports:
//   clk_i, rst_i        system clock, synchronous active-high reset
//   en_i                receiver enable (low: abort silently, stay in HUNT)
//   serial_clk/serial_i asynchronous serial bit clock and data
//   dat_o, len_o        payload (bits >= len_o are zero) and payload length
//   valid_o, ready_i    output handshake
//   err_o               1-cycle pulse on length overrun or timeout
//   ovf_o               1-cycle pulse when a completed frame is dropped
//   frm_cnt_o           count of frames loaded to the output (wraps)
module deserial_frame_rx #(
   parameter int unsigned      MAX_BITS  = 32,
   parameter int unsigned      HDR_W     = 4,
   parameter logic [HDR_W-1:0] HEADER    = HDR_W'(4'b1010),
   parameter int unsigned      FTR_W     = 4,
   parameter logic [FTR_W-1:0] FOOTER    = FTR_W'(4'b0111),
   parameter bit               MSB_FIRST = 1'b1,
   parameter bit               CLK_EDGE  = 1'b0,
   parameter int unsigned      TIMEOUT   = 1024
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              en_i,
   input  logic                              serial_clk,
   input  logic                              serial_i,
   output logic [MAX_BITS-1:0]               dat_o,
   output logic [$clog2(MAX_BITS+1)-1:0]     len_o,
   output logic                              valid_o,
   input  logic                              ready_i,
   output logic                              err_o,
   output logic                              ovf_o,
   output logic [15:0]                       frm_cnt_o
);

   localparam int unsigned LEN_W  = $clog2(MAX_BITS + 1);
   localparam int unsigned SR_W   = MAX_BITS + FTR_W;
   localparam int unsigned CNT_W  = $clog2(SR_W + 1);
   localparam int unsigned IDLE_W = $clog2(TIMEOUT);

   typedef enum logic {S_HUNT = 1'b0, S_DATA = 1'b1} state_e;

   state_e              state_q, state_d;

   logic                sclk_s1, sclk_s2, sclk_s3;
   logic                sdat_s1, sdat_s2;
   logic [HDR_W-1:0]    hunt_sr;
   logic [SR_W-1:0]     data_sr;
   logic [CNT_W-1:0]    cnt;
   logic [IDLE_W-1:0]   idle_cnt;

   logic                edge_c, bit_c;
   logic [HDR_W-1:0]    hunt_shift_c;
   logic [SR_W-1:0]     data_shift_c;
   logic [CNT_W-1:0]    cnt_inc_c;
   logic                hdr_hit_c, ftr_hit_c, ovr_c, tmo_c;
   logic                done_c, err_c;
   logic [LEN_W-1:0]    len_c;
   logic [MAX_BITS-1:0] payload_c, rev_full_c, mask_c, fmt_c;

   // Synchronisers; serial_i is taken from the same stage as the clock edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sclk_s1 <= 1'b0;
         sclk_s2 <= 1'b0;
         sclk_s3 <= 1'b0;
         sdat_s1 <= 1'b0;
         sdat_s2 <= 1'b0;
      end else begin
         sclk_s1 <= serial_clk;
         sclk_s2 <= sclk_s1;
         sclk_s3 <= sclk_s2;
         sdat_s1 <= serial_i;
         sdat_s2 <= sdat_s1;
      end
   end

   assign edge_c = CLK_EDGE ? (sclk_s3 & ~sclk_s2) : (sclk_s2 & ~sclk_s3);
   assign bit_c  = sdat_s2;

   // Shift candidates: newest bit enters at bit 0, so MSB of a window is the oldest bit.
   assign hunt_shift_c = HDR_W'({hunt_sr, bit_c});
   assign data_shift_c = SR_W'({data_sr, bit_c});
   assign cnt_inc_c    = cnt + CNT_W'(1);

   assign hdr_hit_c = edge_c && (hunt_shift_c == HEADER);
   assign ftr_hit_c = edge_c && (cnt_inc_c >= CNT_W'(FTR_W))
                      && (data_shift_c[FTR_W-1:0] == FOOTER);
   assign ovr_c     = edge_c && !ftr_hit_c && (cnt_inc_c == CNT_W'(SR_W));
   assign tmo_c     = !edge_c && (idle_cnt == IDLE_W'(TIMEOUT - 1));

   // Payload formatting: drop footer, optionally reverse over len bits, mask above len.
   assign len_c     = LEN_W'(cnt_inc_c - CNT_W'(FTR_W));
   assign payload_c = MAX_BITS'(data_shift_c >> FTR_W);

   for (genvar g = 0; g < MAX_BITS; g++) begin : g_rev
      assign rev_full_c[g] = payload_c[MAX_BITS-1-g];
   end

   assign mask_c = ~({MAX_BITS{1'b1}} << len_c);
   assign fmt_c  = (MSB_FIRST ? payload_c : (rev_full_c >> (LEN_W'(MAX_BITS) - len_c))) & mask_c;

   // FSM state register.
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= S_HUNT;
      else       state_q <= state_d;
   end

   // FSM next state.
   always_comb begin
      state_d = state_q;
      if (!en_i) begin
         state_d = S_HUNT;
      end else begin
         case (state_q)
            S_HUNT:  if (hdr_hit_c) state_d = S_DATA;
            S_DATA:  if (ftr_hit_c || ovr_c || tmo_c) state_d = S_HUNT;
            default: state_d = S_HUNT;
         endcase
      end
   end

   // FSM decoded outputs.
   always_comb begin
      done_c = 1'b0;
      err_c  = 1'b0;
      if (en_i && (state_q == S_DATA)) begin
         done_c = ftr_hit_c;
         err_c  = ovr_c || tmo_c;
      end
   end

   // Hunt/data shift registers, bit and idle counters, output register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hunt_sr   <= '0;
         data_sr   <= '0;
         cnt       <= '0;
         idle_cnt  <= '0;
         dat_o     <= '0;
         len_o     <= '0;
         valid_o   <= 1'b0;
         err_o     <= 1'b0;
         ovf_o     <= 1'b0;
         frm_cnt_o <= '0;
      end else begin
         err_o <= err_c;
         ovf_o <= 1'b0;

         // Hunt register is zero outside HUNT so every re-entry starts clean.
         if (en_i && (state_q == S_HUNT)) begin
            if (hdr_hit_c)   hunt_sr <= '0;
            else if (edge_c) hunt_sr <= hunt_shift_c;
         end else begin
            hunt_sr <= '0;
         end

         if (en_i && (state_q == S_DATA)) begin
            if (edge_c) begin
               data_sr  <= data_shift_c;
               cnt      <= cnt_inc_c;
               idle_cnt <= '0;
            end else begin
               idle_cnt <= idle_cnt + IDLE_W'(1);
            end
         end else begin
            data_sr  <= '0;
            cnt      <= '0;
            idle_cnt <= '0;
         end

         // Single-entry output; an accept in the completion cycle frees it for the new frame.
         if (done_c && valid_o && !ready_i) begin
            ovf_o <= 1'b1;
         end else if (done_c) begin
            dat_o     <= fmt_c;
            len_o     <= len_c;
            valid_o   <= 1'b1;
            frm_cnt_o <= frm_cnt_o + 16'd1;
         end else if (valid_o && ready_i) begin
            dat_o   <= '0;
            len_o   <= '0;
            valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_deserial_frame_rx.sv
// tb_deserial_frame_rx: directed bench for deserial_frame_rx with a frame scoreboard.
// Two instances share stimulus: u_msb (MSB_FIRST=1) and u_lsb (MSB_FIRST=0).
module tb_deserial_frame_rx;

   typedef struct packed {
      logic [31:0] dat;
      logic [5:0]  len;
   } frame_t;

   logic        clk_i = 1'b0;
   logic        rst_i, en_i, serial_clk, serial_i, ready_i;
   logic [31:0] dat1, dat0;
   logic [5:0]  len1, len0;
   logic        valid1, valid0, err1, err0, ovf1, ovf0;
   logic [15:0] frm1, frm0;

   frame_t q1[$];
   frame_t q0[$];
   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;
   int v1_cyc = 0;
   int err_cyc = 0;
   int ovf_cyc = 0;

   always #5 clk_i = ~clk_i;

   deserial_frame_rx u_msb (
      .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .serial_clk(serial_clk), .serial_i(serial_i),
      .dat_o(dat1), .len_o(len1), .valid_o(valid1), .ready_i(ready_i),
      .err_o(err1), .ovf_o(ovf1), .frm_cnt_o(frm1));

   deserial_frame_rx #(.MSB_FIRST(1'b0)) u_lsb (
      .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .serial_clk(serial_clk), .serial_i(serial_i),
      .dat_o(dat0), .len_o(len0), .valid_o(valid0), .ready_i(ready_i),
      .err_o(err0), .ovf_o(ovf0), .frm_cnt_o(frm0));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #2;
      end
   endtask

   task automatic send_bit(input logic b);
      serial_i = b;
      tick(4);
      serial_clk = 1'b1;
      tick(4);
      serial_clk = 1'b0;
   endtask

   // Sends HEADER + n payload bits (MSB first) + optional FOOTER; the reference model
   // scans the stream for the first footer match and queues the expected frame.
   task automatic send_frame(input logic [35:0] pay, input int n, input bit with_ftr,
                             input bit push);
      bit          s[$];
      logic [3:0]  win  = '0;
      logic [35:0] got  = '0;
      int          cnt  = 0;
      bit          done = 1'b0;
      frame_t      f1, f0;
      for (int i = n - 1; i >= 0; i--) s.push_back(pay[i]);
      if (with_ftr) begin
         s.push_back(1'b0); s.push_back(1'b1); s.push_back(1'b1); s.push_back(1'b1);
      end
      foreach (s[k]) begin
         if (!done) begin
            cnt++;
            win = {win[2:0], s[k]};
            got = {got[34:0], s[k]};
            if (cnt >= 4 && win == 4'b0111) begin
               done = 1'b1;
               if (push) begin
                  f1.len = 6'(cnt - 4);
                  f1.dat = 32'(got >> 4);
                  f0.len = f1.len;
                  f0.dat = '0;
                  for (int j = 0; j < cnt - 4; j++) f0.dat[j] = f1.dat[cnt-5-j];
                  q1.push_back(f1);
                  q0.push_back(f0);
               end
            end else if (cnt == 36) begin
               done = 1'b1;
            end
         end
      end
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      foreach (s[k]) send_bit(s[k]);
   endtask

   initial begin
      int e0, o0;
      frame_t f;
      rst_i = 1'b1; en_i = 1'b1; ready_i = 1'b1; serial_clk = 1'b0; serial_i = 1'b0;

      // Output monitor: pops the scoreboard on every accepted frame.
      fork
         forever begin
            @(negedge clk_i);
            if (!rst_i) begin
               v1_cyc  += int'(valid1);
               err_cyc += int'(err1);
               ovf_cyc += int'(ovf1);
               if (valid1 && ready_i) begin
                  check("msb_frame_expected", 64'(q1.size() != 0), 64'(1));
                  if (q1.size() != 0) begin
                     f = q1.pop_front();
                     check("msb_dat", 64'(dat1), 64'(f.dat));
                     check("msb_len", 64'(len1), 64'(f.len));
                  end
               end
               if (valid0 && ready_i) begin
                  check("lsb_frame_expected", 64'(q0.size() != 0), 64'(1));
                  if (q0.size() != 0) begin
                     f = q0.pop_front();
                     check("lsb_dat", 64'(dat0), 64'(f.dat));
                     check("lsb_len", 64'(len0), 64'(f.len));
                  end
               end
            end
         end
      join_none

      // Reset state
      tick(3);
      check("rst_dat", 64'(dat1), 64'(0));
      check("rst_len", 64'(len1), 64'(0));
      check("rst_valid", 64'(valid1), 64'(0));
      check("rst_err", 64'(err1), 64'(0));
      check("rst_ovf", 64'(ovf1), 64'(0));
      check("rst_frm", 64'(frm1), 64'(0));
      check("rst_valid_lsb", 64'(valid0), 64'(0));
      rst_i = 1'b0;
      tick(2);

      // A5 with ready high: one-cycle valid, counter to 1
      send_frame(36'hA5, 8, 1'b1, 1'b1);
      tick(8);
      check("t1_drained", 64'(q1.size()), 64'(0));
      check("t1_valid_cycles", 64'(v1_cyc), 64'(1));
      check("t1_frm", 64'(frm1), 64'(1));
      check("t1_valid_low", 64'(valid1), 64'(0));

      // 01: reversed on the LSB-first instance
      send_frame(36'h01, 8, 1'b1, 1'b1);
      tick(8);
      check("t2_drained_lsb", 64'(q0.size()), 64'(0));
      check("t2_frm", 64'(frm1), 64'(2));

      // Full-length 32-bit payload
      send_frame(36'hFFFFFFFF, 32, 1'b1, 1'b1);
      tick(8);
      check("full_drained", 64'(q1.size()), 64'(0));
      check("full_frm", 64'(frm1), 64'(3));

      // Overrun: 36 zero bits, no footer
      e0 = err_cyc;
      send_frame(36'h0, 36, 1'b0, 1'b0);
      tick(8);
      check("ovr_err_pulse", 64'(err_cyc - e0), 64'(1));
      check("ovr_no_load", 64'(frm1), 64'(3));
      send_frame(36'hA5, 8, 1'b1, 1'b1);
      tick(8);
      check("ovr_next_hdr", 64'(frm1), 64'(4));

      // Back-pressure: A5 held, 3C dropped with ovf
      ready_i = 1'b0;
      send_frame(36'hA5, 8, 1'b1, 1'b1);
      tick(8);
      check("bp_valid", 64'(valid1), 64'(1));
      o0 = ovf_cyc;
      send_frame(36'h3C, 8, 1'b1, 1'b0);
      tick(8);
      check("bp_ovf_pulse", 64'(ovf_cyc - o0), 64'(1));
      check("bp_dat_kept", 64'(dat1), 64'(32'hA5));
      check("bp_valid_kept", 64'(valid1), 64'(1));
      check("bp_frm", 64'(frm1), 64'(5));
      ready_i = 1'b1;
      tick(3);
      check("bp_valid_drop", 64'(valid1), 64'(0));
      check("bp_drained", 64'(q1.size()), 64'(0));

      // Timeout after 5 data bits
      e0 = err_cyc;
      send_frame(36'b10110, 5, 1'b0, 1'b0);
      tick(1100);
      check("tmo_err_pulse", 64'(err_cyc - e0), 64'(1));
      check("tmo_no_valid", 64'(valid1), 64'(0));

      // Enable low mid-frame: silent abort
      e0 = err_cyc;
      send_frame(36'b11001, 5, 1'b0, 1'b0);
      en_i = 1'b0;
      tick(4);
      en_i = 1'b1;
      tick(1100);
      check("en_no_err", 64'(err_cyc - e0), 64'(0));
      check("en_no_load", 64'(frm1), 64'(5));

      // Zero-length frame held for inspection
      ready_i = 1'b0;
      send_frame(36'h0, 0, 1'b1, 1'b1);
      tick(8);
      check("zero_valid", 64'(valid1), 64'(1));
      check("zero_len", 64'(len1), 64'(0));
      check("zero_dat", 64'(dat1), 64'(0));
      ready_i = 1'b1;
      tick(3);
      check("zero_drained", 64'(q1.size()), 64'(0));

      // Reset with a held frame and a partial frame in progress
      ready_i = 1'b0;
      send_frame(36'hA5, 8, 1'b1, 1'b0);
      tick(8);
      send_frame(36'b101, 3, 1'b0, 1'b0);
      rst_i = 1'b1;
      tick(1);
      check("mid_rst_valid", 64'(valid1), 64'(0));
      check("mid_rst_dat", 64'(dat1), 64'(0));
      check("mid_rst_len", 64'(len1), 64'(0));
      check("mid_rst_frm", 64'(frm1), 64'(0));
      rst_i = 1'b0;
      ready_i = 1'b1;
      tick(2);
      send_frame(36'hA5, 8, 1'b1, 1'b1);
      tick(8);
      check("post_rst_frm", 64'(frm1), 64'(1));
      check("post_rst_drained", 64'(q1.size() + q0.size()), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
